inst_mem_bridge: RTL

- Sits directly upstream of the openmips core's instruction port.
- Turns the core's single-cycle ROM interface (rom_ce/rom_addr/rom_data) into request/acknowledge transactions on a variable-latency instruction memory.
- Holds the last fetched word in a one-entry line buffer and raises a stall request to the core while a miss is outstanding.
- Guards each memory transaction with a timeout that substitutes a NOP and flags an error.

---
 rtl/inst_mem_bridge.sv | 102 ++++++++++
 1 files changed

// File: rtl/inst_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_bridge
// Purpose  : Bridges the core's single-cycle ROM fetch port to a variable-latency
//            req/ack instruction memory through a one-entry line buffer.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_bridge #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INST       = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        fetch_err_o
);

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [29:0] r_tag;
    logic [31:0] r_data;
    logic [7:0]  r_count;
    logic        w_hit;

    assign w_hit = r_valid && (r_tag == rom_addr_i[31:2]);

    // Reset masks the core-facing outputs so a held rom_ce_i cannot leak stale state.
    always_comb begin
        rom_data_o = '0;
        stallreq_o = 1'b0;
        if (!rst && rom_ce_i) begin
            if (w_hit) begin
                rom_data_o = r_data;
            end else begin
                stallreq_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            r_valid     <= 1'b0;
            r_tag       <= '0;
            r_data      <= '0;
            r_count     <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rom_ce_i && !w_hit) begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {rom_addr_i[31:2], 2'b00};
                        r_count    <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack takes priority over an expiring timeout in the same cycle.
                    if (mem_ack_i) begin
                        r_data    <= mem_rdata_i;
                        r_tag     <= mem_addr_o[31:2];
                        r_valid   <= 1'b1;
                        mem_req_o <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_count == c_timeout_last) begin
                        r_data      <= NOP_INST;
                        r_tag       <= mem_addr_o[31:2];
                        r_valid     <= 1'b1;
                        fetch_err_o <= 1'b1;
                        mem_req_o   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
